// File: rtl/param_load_counter.sv
// Parametrised up/down counter with parallel load, preset, wrap/auto-reload/one-shot
// modes and a registered terminal pulse. Optional prescaler enabled by PLC_PRESCALE_EN.
module param_load_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             cten,
    input  logic             up,
    input  logic             prs,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             tc_pulse,
    output logic             done
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    if (WIDTH < 2 || PRESCALE < 1) begin : g_param_check
        $error("param_load_counter: WIDTH must be >= 2 and PRESCALE >= 1");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_tc_pulse;
    logic             w_pulse_nxt;
    logic [WIDTH-1:0] w_term_val;
    logic [WIDTH-1:0] w_stepped;
    logic             w_at_t;
    logic             w_run;
    logic             w_tick;
    logic             w_step;

`ifdef PLC_PRESCALE_EN
    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PS_ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] r_pcnt;
    logic [PW-1:0] w_pcnt_nxt;

    assign w_tick = (r_pcnt == PS_LAST);

    // Prescale count: cleared by preset/load, advances only while enabled and running.
    always_comb begin
        w_pcnt_nxt = r_pcnt;
        if (prs || load) begin
            w_pcnt_nxt = {PW{1'b0}};
        end else if (cten && w_run) begin
            w_pcnt_nxt = w_tick ? {PW{1'b0}} : (r_pcnt + PS_ONE);
        end else begin
            w_pcnt_nxt = r_pcnt;
        end
    end

    // Prescale count register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_pcnt <= {PW{1'b0}};
        end else begin
            r_pcnt <= w_pcnt_nxt;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    assign w_run      = (r_state == ST_RUN);
    assign w_term_val = up ? ALL_ONES : ALL_ZERO;
    assign w_at_t     = (r_out == w_term_val);
    assign w_stepped  = up ? (r_out + ONE) : (r_out - ONE);
    assign w_step     = cten & w_run & w_tick;

    // Next-state, next-count and terminal pulse; preset beats load beats count.
    always_comb begin
        w_state_nxt  = r_state;
        w_out_nxt    = r_out;
        w_reload_nxt = r_reload;
        w_pulse_nxt  = 1'b0;
        if (prs) begin
            w_out_nxt   = ALL_ONES;
            w_state_nxt = ST_RUN;
        end else if (load) begin
            w_out_nxt    = in;
            w_reload_nxt = in;
            w_state_nxt  = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_step && w_at_t) begin
                        w_pulse_nxt = 1'b1;
                        case (mode)
                            2'b01:   w_out_nxt   = r_reload;
                            2'b10:   w_state_nxt = ST_DONE;
                            default: w_out_nxt   = w_stepped;
                        endcase
                    end else if (w_step) begin
                        w_out_nxt = w_stepped;
                    end else begin
                        w_out_nxt = r_out;
                    end
                end
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    // State, counter, reload value and pulse registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= ST_RUN;
            r_out      <= ALL_ZERO;
            r_reload   <= ALL_ZERO;
            r_tc_pulse <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_out      <= w_out_nxt;
            r_reload   <= w_reload_nxt;
            r_tc_pulse <= w_pulse_nxt;
        end
    end

    assign out      = r_out;
    assign tc_pulse = r_tc_pulse;
    assign done     = (r_state == ST_DONE);
    assign tc       = cten & w_at_t & w_run & w_tick;

endmodule
